page_table_walker: RTL
======================

PAGE_TABLE_WALKER -- requirements
Module: page_table_walker

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: memory-wait cycles before abort (used only with PTW_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ptbr  input  32  page-table base; bits [31:12] used.
REQ-005 SHALL have port miss_valid  input  1  TLB-miss walk request.
REQ-006 SHALL have port miss_vaddr  input  32  faulting virtual address.
REQ-007 SHALL have port miss_ready  output  1  walker idle, request acceptable.
REQ-008 SHALL have port mem_req  output  1  PTE read request.
REQ-009 SHALL have port mem_addr  output  32  PTE byte address.
REQ-010 SHALL have port mem_ack  input  1  read-data-valid pulse.
REQ-011 SHALL have port mem_rdata  input  32  PTE data, valid with mem_ack.
REQ-012 SHALL have port tlb_we  output  1  one-cycle TLB fill strobe.
REQ-013 SHALL have port tlb_vpn  output  20  fill virtual page number.
REQ-014 SHALL have port tlb_ppn  output  20  fill physical page number.
REQ-015 SHALL have port tlb_dirty  output  1  fill dirty bit.
REQ-016 SHALL have port page_fault  output  1  one-cycle fault pulse.
REQ-017 SHALL have port fault_vaddr  output  32  address of faulting walk, held until next accept.

Function
REQ-018 SHALL implement states IDLE, WALK_L1, WALK_L2, FILL, FAULT; miss_ready = (state==IDLE).
REQ-019 In IDLE with miss_valid=1, SHALL latch miss_vaddr into vaddr_q and enter WALK_L1 next cycle; miss_valid ignored in all other states.
REQ-020 In WALK_L1 SHALL drive mem_req=1, mem_addr={ptbr[31:12], vaddr_q[31:22], 2'b00}, stable until mem_ack.
REQ-021 On mem_ack in WALK_L1: mem_rdata[0]=1 -> latch mem_rdata[31:12] as l2_base, go WALK_L2; mem_rdata[0]=0 -> go FAULT.
REQ-022 In WALK_L2 SHALL drive mem_req=1, mem_addr={l2_base, vaddr_q[21:12], 2'b00}, stable until mem_ack.
REQ-023 On mem_ack in WALK_L2: mem_rdata[0]=1 -> latch ppn=mem_rdata[31:12], dirty=mem_rdata[1], go FILL; else go FAULT.
REQ-024 mem_ack in the same cycle mem_req first rises SHALL be accepted; mem_ack while mem_req=0 SHALL be ignored.
REQ-025 FILL SHALL last one cycle with tlb_we=1, tlb_vpn=vaddr_q[31:12], tlb_ppn, tlb_dirty, then return to IDLE.
REQ-026 FAULT SHALL last one cycle with page_fault=1, fault_vaddr=vaddr_q, no tlb_we, then return to IDLE.
REQ-027 Minimum latency: accept at cycle T, tlb_we at T+3 with zero-wait memory; miss_ready high again at T+4.
REQ-028 tlb_we and page_fault SHALL never be high together; mem_req SHALL be 0 in IDLE, FILL, FAULT.

Reset
REQ-029 On reset=1 at a clock edge SHALL enter IDLE and clear mem_req, mem_addr, tlb_we, tlb_vpn, tlb_ppn, tlb_dirty, page_fault, fault_vaddr, internal registers to 0, including mid-walk (walk abandoned, no fill, no fault).
REQ-030 mem_ack arriving in the cycle after reset SHALL be ignored.

Configuration
REQ-031 With PTW_TIMEOUT_EN defined, SHALL count cycles spent in WALK_L1/WALK_L2 without mem_ack (counter cleared on state entry); on reaching TIMEOUT_CYCLES SHALL drop mem_req and go FAULT.
REQ-032 Without PTW_TIMEOUT_EN, no counter SHALL exist and the walker SHALL wait indefinitely for mem_ack.

Verification
REQ-033 ptbr=0x0001_0000, miss_vaddr=0x1234_5678, L1 PTE 0x0002_0001, L2 PTE 0xABCDE003, zero-wait -> mem_addr 0x0001_0120 then 0x0002_0D14; tlb_we at T+3, tlb_vpn=0x12345, tlb_ppn=0xABCDE, tlb_dirty=1.
REQ-034 L1 PTE 0x0002_0000 (invalid) -> page_fault pulse, fault_vaddr=0x1234_5678, no tlb_we, single memory read.
REQ-035 mem_ack delayed 5 cycles each level -> mem_req/mem_addr stable throughout; tlb_we at T+13.
REQ-036 reset asserted during WALK_L2 -> next cycle IDLE, all outputs 0, late mem_ack ignored, next miss walks normally.
REQ-037 With PTW_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req drops and page_fault pulses after 4 wait cycles; without macro, mem_req held indefinitely.
REQ-038 miss_valid held high during walk -> only one walk; second request accepted only after return to IDLE.

Source files
------------

// File: rtl/page_table_walker.sv
// Two-level page-table walker: fetches L1 and L2 PTEs on a TLB miss and emits a TLB fill or a page-fault pulse.
// Optional memory-wait abort is enabled by defining PTW_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
`timescale 1ns/1ps
module page_table_walker #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ptbr,
  input  logic        miss_valid,
  input  logic [31:0] miss_vaddr,
  output logic        miss_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        tlb_we,
  output logic [19:0] tlb_vpn,
  output logic [19:0] tlb_ppn,
  output logic        tlb_dirty,
  output logic        page_fault,
  output logic [31:0] fault_vaddr
);

  typedef enum logic [2:0] {IDLE, WALK_L1, WALK_L2, FILL, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [19:0] l2_base_q, l2_base_d;
  logic [19:0] ppn_q, ppn_d;
  logic        dirty_q, dirty_d;
  logic [31:0] fault_vaddr_q, fault_vaddr_d;
  logic        timeout;

  logic unused_bits;
  assign unused_bits = ^{ptbr[11:0], mem_rdata[11:2], 32'(TIMEOUT_CYCLES)};

`ifdef PTW_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  // Aborts in the last allowed wait cycle so mem_req is high for exactly TIMEOUT_CYCLES cycles.
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if ((state_q == WALK_L1 || state_q == WALK_L2) && state_d == state_q)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    vaddr_d       = vaddr_q;
    l2_base_d     = l2_base_q;
    ppn_d         = ppn_q;
    dirty_d       = dirty_q;
    fault_vaddr_d = fault_vaddr_q;
    miss_ready    = 1'b0;
    mem_req       = 1'b0;
    mem_addr      = '0;
    tlb_we        = 1'b0;
    tlb_vpn       = '0;
    tlb_ppn       = '0;
    tlb_dirty     = 1'b0;
    page_fault    = 1'b0;

    case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          vaddr_d = miss_vaddr;
          state_d = WALK_L1;
        end
      end
      WALK_L1: begin
        mem_req  = 1'b1;
        mem_addr = {ptbr[31:12], vaddr_q[31:22], 2'b00};
        if (mem_ack) begin
          if (mem_rdata[0]) begin
            l2_base_d = mem_rdata[31:12];
            state_d   = WALK_L2;
          end else begin
            state_d = FAULT;
          end
        end else if (timeout) begin
          state_d = FAULT;
        end
      end
      WALK_L2: begin
        mem_req  = 1'b1;
        mem_addr = {l2_base_q, vaddr_q[21:12], 2'b00};
        if (mem_ack) begin
          if (mem_rdata[0]) begin
            ppn_d   = mem_rdata[31:12];
            dirty_d = mem_rdata[1];
            state_d = FILL;
          end else begin
            state_d = FAULT;
          end
        end else if (timeout) begin
          state_d = FAULT;
        end
      end
      FILL: begin
        tlb_we    = 1'b1;
        tlb_vpn   = vaddr_q[31:12];
        tlb_ppn   = ppn_q;
        tlb_dirty = dirty_q;
        state_d   = IDLE;
      end
      FAULT: begin
        page_fault = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Captured on entry so the faulting address is visible during the pulse and afterwards.
    if (state_d == FAULT && state_q != FAULT)
      fault_vaddr_d = vaddr_q;
  end

  assign fault_vaddr = fault_vaddr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      vaddr_q       <= '0;
      l2_base_q     <= '0;
      ppn_q         <= '0;
      dirty_q       <= 1'b0;
      fault_vaddr_q <= '0;
    end else begin
      state_q       <= state_d;
      vaddr_q       <= vaddr_d;
      l2_base_q     <= l2_base_d;
      ppn_q         <= ppn_d;
      dirty_q       <= dirty_d;
      fault_vaddr_q <= fault_vaddr_d;
    end
  end

endmodule
